// File: rtl/sort_pkg.sv
// Shared types and constants for the three-word streaming sorter.
// The pad value is all-ones so that unwritten slots always sort to the tail of a frame.
package sort_pkg;

   localparam int WORD_W = 32;
   localparam int SORT_N = 3;

   typedef logic [WORD_W-1:0] data_t;

   localparam data_t PAD = '1;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SORT    = 2'd1,
      EMIT    = 2'd2
   } state_t;

endpackage

// File: rtl/sort3_stream_ctrl_if.sv
// Producer and consumer handshakes of the streaming sorter.
// The slave modport is the controller's view; the master modport is the environment's view.
interface sort3_stream_ctrl_if #(
   parameter int DATA_W = 32
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/sort_net3.sv
// Purely combinational three-input ascending sorting network.
// Three compare-exchange stages: (0,2), then (0,1), then (1,2), unsigned compare.
module sort_net3 #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a0_i,
   input  logic [DATA_W-1:0] a1_i,
   input  logic [DATA_W-1:0] a2_i,
   output logic [DATA_W-1:0] s0_o,
   output logic [DATA_W-1:0] s1_o,
   output logic [DATA_W-1:0] s2_o
);

   logic [DATA_W-1:0] p0_s;
   logic [DATA_W-1:0] p2_s;
   logic [DATA_W-1:0] q1_s;

   // After the first two stages position 0 already holds the global minimum.
   assign p0_s = (a0_i <= a2_i) ? a0_i : a2_i;
   assign p2_s = (a0_i <= a2_i) ? a2_i : a0_i;
   assign s0_o = (p0_s <= a1_i) ? p0_s : a1_i;
   assign q1_s = (p0_s <= a1_i) ? a1_i : p0_s;
   assign s1_o = (q1_s <= p2_s) ? q1_s : p2_s;
   assign s2_o = (q1_s <= p2_s) ? p2_s : q1_s;

endmodule

// File: rtl/sort3_stream_ctrl.sv
// Streaming controller: collects up to three words, sorts them through sort_net3 in a
// single SORT cycle and replays them in ascending order, only the frame's real words.
module sort3_stream_ctrl
   import sort_pkg::*;
#(
   parameter int DATA_W = WORD_W
) (
   input  logic               clk,
   input  logic               rst,
   sort3_stream_ctrl_if.slave bus,
   output logic               busy
);

   localparam logic [DATA_W-1:0] PAD_W  = {DATA_W{PAD[0]}};
   localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [1:0]        len_q, len_d;
   logic [1:0]        idx_q, idx_d;
   logic [DATA_W-1:0] slot_q [SORT_N];
   logic [DATA_W-1:0] slot_d [SORT_N];
   logic [DATA_W-1:0] buf_q  [SORT_N];
   logic [DATA_W-1:0] buf_d  [SORT_N];
   logic [DATA_W-1:0] net_s  [SORT_N];
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic              out_valid_q;
   logic              in_ready_q;
   logic              busy_q;
   logic              in_fire_s;
   logic              out_fire_s;

   sort_net3 #(
      .DATA_W (DATA_W)
   ) u_net (
      .a0_i (slot_q[0]),
      .a1_i (slot_q[1]),
      .a2_i (slot_q[2]),
      .s0_o (net_s[0]),
      .s1_o (net_s[1]),
      .s2_o (net_s[2])
   );

   assign in_fire_s  = bus.in_valid & in_ready_q;
   assign out_fire_s = out_valid_q & bus.out_ready;

   // Next-state logic; output word and last flag are computed one cycle early so they leave registered.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      idx_d      = idx_q;
      slot_d     = slot_q;
      buf_d      = buf_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      case (state_q)
         COLLECT: begin
            if (in_fire_s) begin
               for (int i = 0; i < SORT_N; i++) begin
                  if (cnt_q == 2'(i)) begin
                     slot_d[i] = bus.in_data;
                  end else begin
                     slot_d[i] = slot_q[i];
                  end
               end
               cnt_d = cnt_q + 2'd1;
               if (bus.in_last || (cnt_q == 2'd2)) begin
                  state_d = SORT;
               end else begin
                  state_d = COLLECT;
               end
            end else begin
               state_d = COLLECT;
            end
         end
         SORT: begin
            buf_d      = net_s;
            len_d      = cnt_q;
            idx_d      = 2'd0;
            out_data_d = net_s[0];
            out_last_d = (cnt_q == 2'd1);
            state_d    = EMIT;
         end
         EMIT: begin
            if (out_fire_s) begin
               if (out_last_q) begin
                  cnt_d      = 2'd0;
                  idx_d      = 2'd0;
                  out_data_d = ZERO_W;
                  out_last_d = 1'b0;
                  for (int i = 0; i < SORT_N; i++) begin
                     slot_d[i] = PAD_W;
                  end
                  state_d    = COLLECT;
               end else begin
                  idx_d      = idx_q + 2'd1;
                  // Next word becomes last when idx+1 == len-1.
                  out_last_d = ((idx_q + 2'd2) == len_q);
                  case (idx_q)
                     2'd0:    out_data_d = buf_q[1];
                     2'd1:    out_data_d = buf_q[2];
                     default: out_data_d = out_data_q;
                  endcase
                  state_d    = EMIT;
               end
            end else begin
               state_d = EMIT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   // State, datapath and registered handshake outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= COLLECT;
         cnt_q       <= 2'd0;
         len_q       <= 2'd0;
         idx_q       <= 2'd0;
         for (int i = 0; i < SORT_N; i++) begin
            slot_q[i] <= PAD_W;
            buf_q[i]  <= ZERO_W;
         end
         out_data_q  <= ZERO_W;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         slot_q      <= slot_d;
         buf_q       <= buf_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_valid_q <= (state_d == EMIT);
         in_ready_q  <= (state_d == COLLECT);
         busy_q      <= (state_d != COLLECT);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_sort3_stream_ctrl.sv
// Self-checking bench for sort3_stream_ctrl: directed frames followed by random frames,
// each checked against an insertion-sorted reference list of the words sent.
module tb_sort3_stream_ctrl;

   localparam int NR = 40;

   logic clk;
   logic rst;
   logic busy;

   int errors;
   int checks;
   int n_in;
   int n_out;

   int          rl [NR];
   logic [31:0] rw [NR][3];
   bit          h;
   logic [31:0] nxt;

   sort3_stream_ctrl_if #(.DATA_W(32)) bus ();

   sort3_stream_ctrl #(
      .DATA_W (32)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 3))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(0, 3));
         default: return $urandom;
      endcase
   endfunction

   // Sends one frame, then checks the sorted replay. Called #1 after a posedge.
   task automatic run_frame(input int len, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input bit last3, input int stall_at,
                            input int stall_n, input int rst_after, input bit hold,
                            input logic [31:0] next_w);
      logic [31:0] w [3];
      logic [31:0] q [$];
      logic [31:0] held;
      bit          acc, v, stall, first_stall;
      int          g, k, stall_left, busy_cnt, stalls_exp;
      w[0] = w0; w[1] = w1; w[2] = w2;
      q = {};
      for (int i = 0; i < len; i++) begin
         int p;
         p = 0;
         while (p < q.size() && q[p] <= w[i]) p++;
         q.insert(p, w[i]);
      end
      for (int i = 0; i < len; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = w[i];
         bus.in_last  = (i == len - 1) ? ((len < 3) ? 1'b1 : last3) : 1'b0;
         acc = 1'b0;
         g   = 0;
         while (!acc && g < 50) begin
            g++;
            acc = bus.in_ready;
            @(posedge clk); #1;
         end
         if (!acc) chk("in_accept_timeout", 32'd0, 32'd1);
         n_in++;
      end
      if (hold) begin
         bus.in_valid = 1'b1;
         bus.in_data  = next_w;
         bus.in_last  = 1'b0;
      end else begin
         bus.in_valid = 1'b0;
      end
      chk("sort_out_valid", bus.out_valid, 1'b0);
      chk("sort_in_ready", bus.in_ready, 1'b0);
      chk("sort_busy", busy, 1'b1);
      busy_cnt = (busy === 1'b1) ? 1 : 0;
      @(posedge clk); #1;
      chk("latency_out_valid", bus.out_valid, 1'b1);
      k           = 0;
      g           = 0;
      stall_left  = stall_n;
      first_stall = 1'b1;
      held        = 32'h0;
      while (k < len && g < 200) begin
         g++;
         if (k == rst_after) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("rst_out_valid", bus.out_valid, 1'b0);
            chk("rst_in_ready", bus.in_ready, 1'b1);
            chk("rst_busy", busy, 1'b0);
            chk("rst_out_data", bus.out_data, 32'h0);
            n_in -= (len - k);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            return;
         end
         stall = (k == stall_at) && (stall_left > 0);
         bus.out_ready = !stall;
         v = bus.out_valid;
         chk("out_valid", v, 1'b1);
         chk("out_data", bus.out_data, q[k]);
         chk("out_last", bus.out_last, (k == len - 1));
         chk("emit_in_ready", bus.in_ready, 1'b0);
         if (busy === 1'b1) busy_cnt++;
         if (stall) begin
            if (!first_stall) chk("stall_hold_data", bus.out_data, held);
            held        = bus.out_data;
            first_stall = 1'b0;
            stall_left--;
         end
         @(posedge clk); #1;
         if (v && !stall) begin
            k++;
            n_out++;
         end
      end
      if (k < len) chk("out_timeout", k, len);
      bus.out_ready = 1'b1;
      stalls_exp = (stall_at < len) ? stall_n : 0;
      chk("post_out_valid", bus.out_valid, 1'b0);
      chk("post_in_ready", bus.in_ready, 1'b1);
      chk("post_busy", busy, 1'b0);
      chk("busy_cycles", busy_cnt, 1 + len + stalls_exp);
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      n_in          = 0;
      n_out         = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = 32'h0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_in_ready", bus.in_ready, 1'b1);
      chk("reset_out_valid", bus.out_valid, 1'b0);
      chk("reset_out_last", bus.out_last, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_out_data", bus.out_data, 32'h0);

      // Directed frames
      run_frame(3, 32'd5, 32'd1, 32'd3, 1'b1, 9, 0, 9, 1'b0, 32'h0);
      run_frame(2, 32'd9, 32'd2, 32'h0, 1'b0, 9, 0, 9, 1'b0, 32'h0);
      run_frame(3, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1'b1, 1, 4, 9, 1'b0, 32'h0);
      run_frame(1, 32'd7, 32'h0, 32'h0, 1'b0, 9, 0, 9, 1'b0, 32'h0);
      run_frame(3, 32'd8, 32'd6, 32'd4, 1'b1, 9, 0, 2, 1'b0, 32'h0);
      run_frame(3, 32'd3, 32'd2, 32'd1, 1'b1, 9, 0, 9, 1'b0, 32'h0);
      run_frame(3, 32'd4, 32'd9, 32'd1, 1'b1, 9, 0, 9, 1'b1, 32'd12);
      run_frame(2, 32'd12, 32'd5, 32'h0, 1'b1, 9, 0, 9, 1'b1, 32'd6);
      run_frame(3, 32'd6, 32'd6, 32'd2, 1'b0, 9, 0, 9, 1'b0, 32'h0);

      // Random frames, some back-to-back with in_valid held
      for (int f = 0; f < NR; f++) begin
         rl[f] = $urandom_range(1, 3);
         for (int j = 0; j < 3; j++) rw[f][j] = rnd_word();
      end
      for (int f = 0; f < NR; f++) begin
         if (f < NR - 1) begin
            nxt = rw[f + 1][0];
            h   = ($urandom_range(0, 1) == 1);
         end else begin
            nxt = 32'h0;
            h   = 1'b0;
         end
         run_frame(rl[f], rw[f][0], rw[f][1], rw[f][2], ($urandom_range(0, 1) == 1),
                   $urandom_range(0, 3), $urandom_range(1, 3), 9, h, nxt);
      end

      chk("words_in_eq_out", n_out, n_in);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
